// File: rtl/idex_shift_stage.sv
// ID/EX pipeline register for shift instructions with EX-side rs/rt operand forwarding.
// Registered operands are re-resolved every cycle against the live EX/MEM and MEM/WB bypass buses.
module idex_shift_stage #(
  parameter int DATA_W     = 32,
  parameter int SHAMT_W    = 5,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [1:0]            id_shift_op,
  input  logic                  id_shamt_src,
  input  logic [SHAMT_W-1:0]    id_shamt,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exmem_wr_en,
  input  logic [REG_ADDR_W-1:0] exmem_wr_addr,
  input  logic [DATA_W-1:0]     exmem_wr_data,
  input  logic                  memwb_wr_en,
  input  logic [REG_ADDR_W-1:0] memwb_wr_addr,
  input  logic [DATA_W-1:0]     memwb_wr_data,
  output logic                  ex_valid,
  output logic [1:0]            ex_shift_op,
  output logic [DATA_W-1:0]     ex_rt,
  output logic [SHAMT_W-1:0]    ex_shamt,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic [3:0]            ex_fwd_sel
);

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_EXMEM   = 2'b01;
  localparam logic [1:0] SEL_MEMWB   = 2'b10;

  logic                  r_valid;
  logic [1:0]            r_shift_op;
  logic                  r_shamt_src;
  logic [SHAMT_W-1:0]    r_shamt;
  logic [REG_ADDR_W-1:0] r_rs_addr;
  logic [REG_ADDR_W-1:0] r_rt_addr;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic [DATA_W-1:0]     r_rs_data;
  logic [DATA_W-1:0]     r_rt_data;

  logic [1:0]            w_id_shift_op;
  logic [DATA_W-1:0]     w_rs_fwd;
  logic [DATA_W-1:0]     w_rt_fwd;
  logic [1:0]            w_rs_sel;
  logic [1:0]            w_rt_sel;
  logic                  w_unused_rs_hi;

  // Reserved encoding 11 behaves as SLL, so normalise it once at capture.
  assign w_id_shift_op = (id_shift_op == 2'b11) ? 2'b00 : id_shift_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_shift_op  <= '0;
      r_shamt_src <= 1'b0;
      r_shamt     <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_shift_op  <= '0;
      r_shamt_src <= 1'b0;
      r_shamt     <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
    end else if (!stall) begin
      r_valid     <= id_valid;
      r_shift_op  <= w_id_shift_op;
      r_shamt_src <= id_shamt_src;
      r_shamt     <= id_shamt;
      r_rs_addr   <= id_rs_addr;
      r_rt_addr   <= id_rt_addr;
      r_rd_addr   <= id_rd_addr;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
    end
  end

  // EX/MEM is the younger producer, so it is checked first; r0 is hardwired zero and never bypassed.
  always_comb begin
    w_rs_fwd = r_rs_data;
    w_rs_sel = SEL_REGFILE;
    if (exmem_wr_en && (exmem_wr_addr == r_rs_addr) && (r_rs_addr != '0)) begin
      w_rs_fwd = exmem_wr_data;
      w_rs_sel = SEL_EXMEM;
    end else if (memwb_wr_en && (memwb_wr_addr == r_rs_addr) && (r_rs_addr != '0)) begin
      w_rs_fwd = memwb_wr_data;
      w_rs_sel = SEL_MEMWB;
    end
  end

  always_comb begin
    w_rt_fwd = r_rt_data;
    w_rt_sel = SEL_REGFILE;
    if (exmem_wr_en && (exmem_wr_addr == r_rt_addr) && (r_rt_addr != '0)) begin
      w_rt_fwd = exmem_wr_data;
      w_rt_sel = SEL_EXMEM;
    end else if (memwb_wr_en && (memwb_wr_addr == r_rt_addr) && (r_rt_addr != '0)) begin
      w_rt_fwd = memwb_wr_data;
      w_rt_sel = SEL_MEMWB;
    end
  end

  // Variable shifts use only the low rs bits, so the amount wraps modulo DATA_W.
  assign w_unused_rs_hi = ^w_rs_fwd[DATA_W-1:SHAMT_W];

  assign ex_valid    = r_valid;
  assign ex_shift_op = r_shift_op;
  assign ex_rt       = w_rt_fwd;
  assign ex_shamt    = r_shamt_src ? w_rs_fwd[SHAMT_W-1:0] : r_shamt;
  assign ex_rd_addr  = r_rd_addr;
  assign ex_fwd_sel  = {(r_shamt_src ? w_rs_sel : SEL_REGFILE), w_rt_sel};

endmodule

// File: tb/tb_idex_shift_stage.sv
// Self-checking bench for idex_shift_stage: directed pipeline scenarios plus randomized traffic,
// scored against a behavioural model of the ID/EX register and its forwarding rules.
module tb_idex_shift_stage;

  localparam int DATA_W = 32;
  localparam int SHAMT_W = 5;
  localparam int REG_ADDR_W = 5;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [1:0]  id_shift_op;
  logic        id_shamt_src;
  logic [4:0]  id_shamt;
  logic [4:0]  id_rs_addr;
  logic [31:0] id_rs_data;
  logic [4:0]  id_rt_addr;
  logic [31:0] id_rt_data;
  logic [4:0]  id_rd_addr;
  logic        stall;
  logic        flush;
  logic        exmem_wr_en;
  logic [4:0]  exmem_wr_addr;
  logic [31:0] exmem_wr_data;
  logic        memwb_wr_en;
  logic [4:0]  memwb_wr_addr;
  logic [31:0] memwb_wr_data;
  logic        ex_valid;
  logic [1:0]  ex_shift_op;
  logic [31:0] ex_rt;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_rd_addr;
  logic [3:0]  ex_fwd_sel;

  typedef struct packed {
    logic        idValid;
    logic [1:0]  op;
    logic        src;
    logic [4:0]  shamt;
    logic [4:0]  rsA;
    logic [31:0] rsD;
    logic [4:0]  rtA;
    logic [31:0] rtD;
    logic [4:0]  rdA;
    logic        stall;
    logic        flush;
    logic        exEn;
    logic [4:0]  exA;
    logic [31:0] exD;
    logic        memEn;
    logic [4:0]  memA;
    logic [31:0] memD;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  op;
    logic        src;
    logic [4:0]  shamt;
    logic [4:0]  rsA;
    logic [31:0] rsD;
    logic [4:0]  rtA;
    logic [31:0] rtD;
    logic [4:0]  rdA;
  } model_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  op;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic [3:0]  fwd;
  } expect_t;

  model_t  model;
  expect_t sbQ[$];
  int      checks;
  int      failures;

  idex_shift_stage #(
    .DATA_W(DATA_W),
    .SHAMT_W(SHAMT_W),
    .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .id_shift_op(id_shift_op),
    .id_shamt_src(id_shamt_src),
    .id_shamt(id_shamt),
    .id_rs_addr(id_rs_addr),
    .id_rs_data(id_rs_data),
    .id_rt_addr(id_rt_addr),
    .id_rt_data(id_rt_data),
    .id_rd_addr(id_rd_addr),
    .stall(stall),
    .flush(flush),
    .exmem_wr_en(exmem_wr_en),
    .exmem_wr_addr(exmem_wr_addr),
    .exmem_wr_data(exmem_wr_data),
    .memwb_wr_en(memwb_wr_en),
    .memwb_wr_addr(memwb_wr_addr),
    .memwb_wr_data(memwb_wr_data),
    .ex_valid(ex_valid),
    .ex_shift_op(ex_shift_op),
    .ex_rt(ex_rt),
    .ex_shamt(ex_shamt),
    .ex_rd_addr(ex_rd_addr),
    .ex_fwd_sel(ex_fwd_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The value a register read sees in EX: youngest matching writer, never r0.
  function automatic void resolve(input logic [4:0] addr, input logic [31:0] rfData, input stim_t s,
                                  output logic [31:0] val, output logic [1:0] sel);
    if (s.exEn && s.exA == addr && addr != 0) begin
      val = s.exD;
      sel = 2'd1;
    end else if (s.memEn && s.memA == addr && addr != 0) begin
      val = s.memD;
      sel = 2'd2;
    end else begin
      val = rfData;
      sel = 2'd0;
    end
  endfunction

  function automatic expect_t predict(input model_t m, input stim_t s);
    expect_t     e;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic [1:0]  rsSel;
    logic [1:0]  rtSel;
    resolve(m.rsA, m.rsD, s, rsVal, rsSel);
    resolve(m.rtA, m.rtD, s, rtVal, rtSel);
    e.valid = m.valid;
    e.op    = m.op;
    e.rt    = rtVal;
    e.shamt = m.src ? 5'(rsVal % DATA_W) : m.shamt;
    e.rd    = m.rdA;
    e.fwd   = {(m.src ? rsSel : 2'd0), rtSel};
    return e;
  endfunction

  function automatic expect_t mkExp(input logic v, input logic [1:0] op, input logic [31:0] rt,
                                    input logic [4:0] sh, input logic [4:0] rd, input logic [3:0] fwd);
    expect_t e;
    e.valid = v;
    e.op    = op;
    e.rt    = rt;
    e.shamt = sh;
    e.rd    = rd;
    e.fwd   = fwd;
    return e;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.idValid = 1'($urandom_range(0, 1));
    s.op      = 2'($urandom_range(0, 3));
    s.src     = 1'($urandom_range(0, 1));
    s.shamt   = 5'($urandom_range(0, 31));
    s.rsA     = 5'($urandom_range(0, 7));
    s.rsD     = $urandom;
    s.rtA     = 5'($urandom_range(0, 7));
    s.rtD     = $urandom;
    s.rdA     = 5'($urandom_range(0, 31));
    s.stall   = ($urandom_range(0, 9) < 2);
    s.flush   = ($urandom_range(0, 9) == 0);
    s.exEn    = 1'($urandom_range(0, 1));
    s.exA     = 5'($urandom_range(0, 7));
    s.exD     = $urandom;
    s.memEn   = 1'($urandom_range(0, 1));
    s.memA    = 5'($urandom_range(0, 7));
    s.memD    = $urandom;
    return s;
  endfunction

  task automatic driveInputs(input stim_t s);
    id_valid      = s.idValid;
    id_shift_op   = s.op;
    id_shamt_src  = s.src;
    id_shamt      = s.shamt;
    id_rs_addr    = s.rsA;
    id_rs_data    = s.rsD;
    id_rt_addr    = s.rtA;
    id_rt_data    = s.rtD;
    id_rd_addr    = s.rdA;
    stall         = s.stall;
    flush         = s.flush;
    exmem_wr_en   = s.exEn;
    exmem_wr_addr = s.exA;
    exmem_wr_data = s.exD;
    memwb_wr_en   = s.memEn;
    memwb_wr_addr = s.memA;
    memwb_wr_data = s.memD;
  endtask

  // Called just after a rising edge: drive this cycle's buses and next ID fields, queue the expectation, then advance.
  task automatic applyStimulus(input stim_t s, input bit useDir, input expect_t dir);
    driveInputs(s);
    sbQ.push_back(useDir ? dir : predict(model, s));
    @(posedge clk);
    if (s.flush) begin
      model = '0;
    end else if (!s.stall) begin
      model.valid = s.idValid;
      model.op    = (s.op == 2'd3) ? 2'd0 : s.op;
      model.src   = s.src;
      model.shamt = s.shamt;
      model.rsA   = s.rsA;
      model.rsD   = s.rsD;
      model.rtA   = s.rtA;
      model.rtD   = s.rtD;
      model.rdA   = s.rdA;
    end
    #1;
  endtask

  // Reset is raised between edges; the monitor checks the zeroed outputs before the next edge.
  task automatic doReset();
    stim_t s;
    s = randStim();
    driveInputs(s);
    rst = 1'b1;
    model = '0;
    sbQ.push_back(mkExp(1'b0, 2'd0, 32'd0, 5'd0, 5'd0, 4'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    cmp("ex_valid", 32'(ex_valid), 32'(e.valid));
    cmp("ex_shift_op", 32'(ex_shift_op), 32'(e.op));
    cmp("ex_rt", ex_rt, e.rt);
    cmp("ex_shamt", 32'(ex_shamt), 32'(e.shamt));
    cmp("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
    cmp("ex_fwd_sel", 32'(ex_fwd_sel), 32'(e.fwd));
  endtask

  // Monitor: outputs are sampled on the falling edge, away from capture.
  initial begin
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
    end
  end

  initial begin
    stim_t   s;
    expect_t none;
    checks   = 0;
    failures = 0;
    none     = '0;
    rst      = 1'b1;
    s        = '0;
    driveInputs(s);
    model    = '0;
    @(posedge clk);
    #1;
    doReset();

    // SLL immediate, no bypass matches
    s = randStim(); s.stall = 0; s.flush = 0; s.exEn = 0; s.memEn = 0;
    s.idValid = 1; s.op = 2'd0; s.src = 0; s.shamt = 5'd4;
    s.rsA = 5'd1; s.rsD = 32'd0; s.rtA = 5'd5; s.rtD = 32'h0000_00F0; s.rdA = 5'd9;
    applyStimulus(s, 1'b0, none);

    // SLLV with rs forwarded from EX/MEM; amount 0x23 wraps to 3
    s = randStim(); s.stall = 0; s.flush = 0; s.exEn = 0; s.memEn = 0;
    s.idValid = 1; s.op = 2'd0; s.src = 1; s.shamt = 5'd17;
    s.rsA = 5'd3; s.rsD = 32'h20; s.rtA = 5'd4; s.rtD = 32'h11; s.rdA = 5'd10;
    applyStimulus(s, 1'b1, mkExp(1'b1, 2'd0, 32'h0000_00F0, 5'd4, 5'd9, 4'b0000));

    // SRA with rt matching both bypass stages
    s = randStim(); s.stall = 0; s.flush = 0;
    s.exEn = 1; s.exA = 5'd3; s.exD = 32'h0000_0023; s.memEn = 0;
    s.idValid = 1; s.op = 2'd2; s.src = 0; s.shamt = 5'd1;
    s.rsA = 5'd0; s.rsD = 32'd0; s.rtA = 5'd7; s.rtD = 32'h1234; s.rdA = 5'd11;
    applyStimulus(s, 1'b1, mkExp(1'b1, 2'd0, 32'h11, 5'd3, 5'd10, 4'b0100));

    // Reserved op, rt=r0 with writers targeting r0, max immediate amount
    s = randStim(); s.stall = 0; s.flush = 0;
    s.exEn = 1; s.exA = 5'd7; s.exD = 32'hAAAA_0000; s.memEn = 1; s.memA = 5'd7; s.memD = 32'h5555;
    s.idValid = 1; s.op = 2'd3; s.src = 0; s.shamt = 5'd31;
    s.rsA = 5'd0; s.rsD = 32'd0; s.rtA = 5'd0; s.rtD = 32'd0; s.rdA = 5'd0;
    applyStimulus(s, 1'b1, mkExp(1'b1, 2'd2, 32'hAAAA_0000, 5'd1, 5'd11, 4'b0001));

    // SRLV with rs forwarded from MEM/WB
    s = randStim(); s.stall = 0; s.flush = 0;
    s.exEn = 1; s.exA = 5'd0; s.exD = 32'hFFFF_FFFF; s.memEn = 1; s.memA = 5'd0; s.memD = 32'hFFFF_FFFF;
    s.idValid = 1; s.op = 2'd1; s.src = 1; s.shamt = 5'd9;
    s.rsA = 5'd6; s.rsD = 32'd0; s.rtA = 5'd2; s.rtD = 32'h8000_0000; s.rdA = 5'd12;
    applyStimulus(s, 1'b1, mkExp(1'b1, 2'd0, 32'd0, 5'd31, 5'd0, 4'b0000));

    // Three stall cycles: fields hold while forwarding tracks the live buses
    s = randStim(); s.stall = 1; s.flush = 0;
    s.exEn = 1; s.exA = 5'd5; s.exD = 32'h1; s.memEn = 1; s.memA = 5'd6; s.memD = 32'hFFFF_FFE5;
    applyStimulus(s, 1'b1, mkExp(1'b1, 2'd1, 32'h8000_0000, 5'd5, 5'd12, 4'b1000));
    s = randStim(); s.stall = 1; s.flush = 0;
    s.exEn = 1; s.exA = 5'd2; s.exD = 32'h1357; s.memEn = 0;
    applyStimulus(s, 1'b1, mkExp(1'b1, 2'd1, 32'h1357, 5'd0, 5'd12, 4'b0001));
    s = randStim(); s.stall = 1; s.flush = 0; s.exEn = 0; s.memEn = 0;
    applyStimulus(s, 1'b1, mkExp(1'b1, 2'd1, 32'h8000_0000, 5'd0, 5'd12, 4'b0000));
    s = randStim(); s.stall = 1; s.flush = 1; s.exEn = 0; s.memEn = 0;
    applyStimulus(s, 1'b1, mkExp(1'b1, 2'd1, 32'h8000_0000, 5'd0, 5'd12, 4'b0000));
    s = randStim(); s.stall = 0; s.flush = 0;
    applyStimulus(s, 1'b1, mkExp(1'b0, 2'd0, 32'd0, 5'd0, 5'd0, 4'd0));

    for (int i = 0; i < 300; i++) begin
      s = randStim();
      applyStimulus(s, 1'b0, none);
    end
    doReset();
    for (int i = 0; i < 300; i++) begin
      s = randStim();
      applyStimulus(s, 1'b0, none);
    end

    #20;
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
